// File: rtl/mac_cfg_sequencer.sv
// Sequencer for the MAC array and mac_combiner: owns the combiner mode,
// gates operand beats, waits out the MAC pipeline and hands off the result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a cfg change or the first beat of an accumulation
// S_RUN    | accepting the remaining beats of the accumulation
// S_WAIT   | last beat taken, MAC pipeline draining (PIPE_LAT cycles)
// S_OUT    | combiner outputs final, out_valid held until out_ready
// S_SETTLE | cfg just changed, operands held off for SETTLE cycles
module mac_cfg_sequencer #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 2,
    parameter int SETTLE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_req,
    input  logic             cfg_req_valid,
    output logic             cfg_req_ready,
    input  logic [LEN_W-1:0] acc_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mac_en,
    output logic             mac_clear,
    output logic [1:0]       cfg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [1:0] MAC_SINGLE = 2'b00;
    localparam logic [1:0] MAC_DUAL   = 2'b01;
    localparam logic [1:0] MAC_QUAD   = 2'b10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_OUT    = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    // One shared down-counter serves both WAIT and SETTLE; it is loaded with
    // (length - 1) and the phase ends on its terminal count of zero.
    localparam int TMR_MAX = (PIPE_LAT > SETTLE) ? PIPE_LAT : SETTLE;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int PIPE_LD_I   = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam int SETTLE_LD_I = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [TMR_W-1:0] PIPE_LD   = TMR_W'(PIPE_LD_I);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_LD_I);

    logic [2:0]       state_q, state_d;
    logic [1:0]       cfg_q, cfg_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic cfg_acc;
    logic beat;
    logic last_beat;
    logic [1:0] cfg_dec;

    // rst_n gating keeps the handshakes low while reset is asserted.
    assign in_ready      = rst_n && (((state_q == S_IDLE) && !cfg_req_valid) || (state_q == S_RUN));
    assign cfg_req_ready = rst_n && (state_q == S_IDLE) && cfg_req_valid;
    assign mac_en        = in_valid && in_ready;
    assign mac_clear     = mac_en && (state_q == S_IDLE);
    assign out_valid     = (state_q == S_OUT);
    assign busy          = (state_q != S_IDLE);
    assign cfg           = cfg_q;

    assign cfg_acc = cfg_req_ready;
    assign beat    = mac_en;
    assign cfg_dec = ((cfg_req == MAC_DUAL) || (cfg_req == MAC_QUAD)) ? cfg_req : MAC_SINGLE;

    assign last_beat = beat &&
        (((state_q == S_IDLE) && (acc_len <= LEN_W'(1))) ||
         ((state_q == S_RUN) && ((cnt_q + LEN_W'(1)) == len_q)));

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_acc) begin
                    cfg_d = cfg_dec;
                    if (SETTLE > 0) begin
                        state_d = S_SETTLE;
                        tmr_d   = SETTLE_LD;
                    end
                end else if (beat) begin
                    len_d   = (acc_len == '0) ? LEN_W'(1) : acc_len;
                    cnt_d   = LEN_W'(1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (beat) begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_WAIT: begin
                if (tmr_q == '0) begin
                    state_d = S_OUT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Final beat bypasses RUN's beat counting and starts the drain.
        if (last_beat) begin
            if (PIPE_LAT > 0) begin
                state_d = S_WAIT;
                tmr_d   = PIPE_LD;
            end else begin
                state_d = S_OUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cfg_q   <= MAC_SINGLE;
            len_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
        end
    end

endmodule

// File: tb/tb_mac_cfg_sequencer.sv
// Randomized bench for mac_cfg_sequencer against a cycle-timeline model that
// tracks beats remaining, result due time and the cycle the block is free again.
module tb_mac_cfg_sequencer;

    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 2;
    localparam int SETTLE   = 1;
    localparam int NCYC     = 4000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       cfg_req;
    logic             cfg_req_valid;
    logic             cfg_req_ready;
    logic [LEN_W-1:0] acc_len;
    logic             in_valid;
    logic             in_ready;
    logic             mac_en;
    logic             mac_clear;
    logic [1:0]       cfg;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int         beats_left;
    bit         res_pend;
    int         out_at;
    int         idle_from;
    logic [1:0] m_cfg;
    int         cyc;
    int         n_resets;
    int         n_results;

    mac_cfg_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT), .SETTLE(SETTLE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_req       (cfg_req),
        .cfg_req_valid (cfg_req_valid),
        .cfg_req_ready (cfg_req_ready),
        .acc_len       (acc_len),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mac_en        (mac_en),
        .mac_clear     (mac_clear),
        .cfg           (cfg),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        beats_left = 0;
        res_pend   = 1'b0;
        out_at     = 0;
        idle_from  = 0;
        m_cfg      = 2'b00;
    endtask

    task automatic zero_inputs();
        cfg_req       = 2'b00;
        cfg_req_valid = 1'b0;
        acc_len       = '0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
    endtask

    task automatic drive_random();
        cfg_req_valid = ($urandom_range(0, 99) < 8);
        cfg_req       = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0)
            acc_len = LEN_W'($urandom_range(7, 12));
        else
            acc_len = LEN_W'($urandom_range(0, 6));
        in_valid  = ($urandom_range(0, 99) < 75);
        out_ready = ($urandom_range(0, 99) < 55);
    endtask

    initial begin
        bit m_idle;
        bit e_in_ready;
        bit e_cfg_rdy;
        bit e_mac_en;
        bit e_out_valid;

        cyc       = 0;
        n_resets  = 0;
        n_results = 0;
        zero_inputs();
        model_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cfg",      32'(cfg),      32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_out_valid",32'(out_valid),32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_cfg",      32'(cfg),      32'd0);
        chk("idle_busy",     32'(busy),     32'd0);

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            drive_random();
            @(negedge clk);
            cyc++;

            m_idle      = (beats_left == 0) && !res_pend && (cyc >= idle_from);
            e_in_ready  = m_idle ? !cfg_req_valid : (beats_left > 0);
            e_cfg_rdy   = m_idle && cfg_req_valid;
            e_mac_en    = in_valid && e_in_ready;
            e_out_valid = res_pend && (cyc >= out_at);

            chk("in_ready",      32'(in_ready),      32'(e_in_ready));
            chk("cfg_req_ready", 32'(cfg_req_ready), 32'(e_cfg_rdy));
            chk("mac_en",        32'(mac_en),        32'(e_mac_en));
            chk("mac_clear",     32'(mac_clear),     32'(m_idle && e_mac_en));
            chk("out_valid",     32'(out_valid),     32'(e_out_valid));
            chk("busy",          32'(busy),          32'(!m_idle));
            chk("cfg",           32'(cfg),           32'(m_cfg));

            // abort an accumulation in progress with an asynchronous reset
            if (beats_left > 0 && !m_idle && (n == 1000 || n == 2500 || (n > 3000 && n_resets < 3))) begin
                #2;
                zero_inputs();
                rst_n = 1'b0;
                #1;
                chk("abort_out_valid", 32'(out_valid), 32'd0);
                chk("abort_busy",      32'(busy),      32'd0);
                chk("abort_cfg",       32'(cfg),       32'd0);
                chk("abort_in_ready",  32'(in_ready),  32'd0);
                chk("abort_mac_en",    32'(mac_en),    32'd0);
                n_resets++;
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
                continue;
            end

            if (e_cfg_rdy) begin
                m_cfg     = (cfg_req == 2'b01 || cfg_req == 2'b10) ? cfg_req : 2'b00;
                idle_from = cyc + 1 + SETTLE;
            end else if (e_mac_en) begin
                if (m_idle)
                    beats_left = (acc_len == '0) ? 1 : int'(acc_len);
                beats_left--;
                if (beats_left == 0) begin
                    res_pend = 1'b1;
                    out_at   = cyc + 1 + PIPE_LAT;
                end
            end
            if (e_out_valid && out_ready) begin
                res_pend  = 1'b0;
                idle_from = cyc + 1;
                n_results++;
            end
        end

        chk("results_seen", 32'(n_results > 20), 32'd1);
        chk("resets_seen",  32'(n_resets > 0),   32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_cfg_sequencer.md
Name: mac_cfg_sequencer

Overview:
Control block for the MAC array and its mac_combiner stage.
- Owns the combiner's cfg (single/dual/quad) and changes it only between accumulations.
- Gates operand beats into the MAC array with a valid/ready handshake and counts accumulation length.
- Clears accumulators on the first beat, waits out the MAC pipeline, then presents a result-valid handshake to the consumer.

Parameters:
LEN_W, 8, width of acc_len and the beat counter.
PIPE_LAT, 2, cycles from the last accepted beat until the combiner outputs are final (0 legal).
SETTLE, 1, idle cycles after a cfg change before operands are accepted again (0 legal).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
cfg_req  in  2  requested mode, encoded with mac_const.vh macros MAC_SINGLE/MAC_DUAL/MAC_QUAD
cfg_req_valid  in  1  mode-change request
cfg_req_ready  out  1  mode-change accepted this cycle
acc_len  in  LEN_W  beats per accumulation, sampled on the first beat
in_valid  in  1  operand beat available
in_ready  out  1  operand beat accepted when in_valid and in_ready are both high
mac_en  out  1  MAC array enable; equals in_valid & in_ready
mac_clear  out  1  high with the first beat of an accumulation
cfg  out  2  registered mode to mac_combiner
out_valid  out  1  combiner outputs final
out_ready  in  1  consumer takes result
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; cfg=MAC_SINGLE; all counters 0.
  - out_valid=0, cfg_req_ready=0, in_ready=0, mac_en=0, mac_clear=0, busy=0.
- Reset mid-operation aborts immediately. No result is emitted and cfg returns to MAC_SINGLE.
- States: IDLE, RUN, WAIT, OUT, SETTLE.
- IDLE:
  - cfg_req_ready = cfg_req_valid.
  - in_ready = !cfg_req_valid. A cfg request wins over a simultaneous operand beat, and that beat is not taken.
  - On a cfg accept:
    - cfg is updated at the next edge.
    - Any encoding other than MAC_DUAL or MAC_QUAD is stored as MAC_SINGLE.
    - Next state is SETTLE; if SETTLE=0, next state is IDLE.
  - On a beat accept:
    - mac_clear=1.
    - len_q = acc_len, with 0 treated as 1.
    - cnt = 1.
    - Next state is RUN; if len_q==1, next state is WAIT.
- RUN:
  - in_ready=1. cfg_req_ready=0.
  - Each accepted beat increments cnt; mac_clear=0.
  - On the beat where cnt becomes len_q, go to WAIT. Idle cycles (in_valid low) are allowed.
- WAIT:
  - in_ready=0.
  - Count PIPE_LAT cycles, then go to OUT. If PIPE_LAT=0, go directly to OUT.
- Result timing: with the last beat accepted at cycle t, out_valid is first high at t+1+PIPE_LAT.
- OUT:
  - out_valid=1 and held until out_ready. mac_en=0, so the combiner outputs stay stable.
  - On out_valid & out_ready, go to IDLE. A new beat can be accepted the following cycle.
- SETTLE:
  - in_ready=0, cfg_req_ready=0.
  - Count SETTLE cycles, then go to IDLE.
- cfg never changes outside the IDLE→SETTLE transition. A cfg_req_valid held high during RUN/WAIT/OUT waits in IDLE.
- All outputs are driven from the state register and counters, plus the combinational handshake terms listed above. There is no combinational path from out_ready to in_ready.

Test Plan:
- Reset then idle → cfg=MAC_SINGLE, busy=0, in_ready=1. Assert rst_n low during RUN → out_valid=0 and state=IDLE in the same cycle.
- acc_len=4, PIPE_LAT=2, in_valid continuous from cycle 10 → mac_en high in cycles 10–13, mac_clear only in cycle 10, out_valid rises at cycle 16. Holding out_ready=0 for 3 cycles keeps out_valid high; busy drops the cycle after the handshake.
- acc_len=0 → exactly one beat is accepted, mac_clear=mac_en=1 on it, and out_valid appears PIPE_LAT+1 cycles later.
- In IDLE, cfg_req_valid=1 (MAC_QUAD) and in_valid=1 in the same cycle → beat not taken; cfg=MAC_QUAD next cycle; in_ready=0 for SETTLE cycles, then the beat is accepted.
- cfg_req_valid=1 (MAC_DUAL) asserted mid-RUN with acc_len=3 → cfg stays unchanged until the OUT handshake completes, then the request is accepted in IDLE.
- cfg_req=2'b11 → cfg becomes MAC_SINGLE. Gaps in in_valid during RUN (acc_len=5, 2 gaps) → exactly 5 mac_en pulses, and out_valid comes PIPE_LAT+1 cycles after the 5th pulse.
